sprite_blitter: RTL and testbench

Writes one sprite from a synchronous sprite ROM into the game frame buffer at a requested screen position. It skips transparent pixels and clips at the screen edges. It is the write side of the frame-buffer path: the display side reads palette indices out of the buffer and drives the VGA pixels. The game logic starts it once per sprite per frame.

---
 rtl/sprite_blit_pkg.sv | 13 +
 rtl/sprite_blit_addr.sv | 34 +++
 rtl/sprite_blitter.sv | 108 ++++++++++
 tb/tb_sprite_blitter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_blit_pkg.sv
// Shared constants and FSM state type for the sprite blitter.
package sprite_blit_pkg;
  localparam int SPR_W_DEF  = 64;
  localparam int SPR_H_DEF  = 64;
  localparam int FB_W_DEF   = 320;
  localparam int FB_H_DEF   = 240;
  localparam int IDX_W_DEF  = 4;
  localparam int FB_ADDR_W  = 17;
  localparam int ROM_ADDR_W = 12;
  localparam int POS_W      = 10;

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;
endpackage

// File: rtl/sprite_blit_addr.sv
// Address generation: ROM address for the current source pixel, frame-buffer
// address for its destination, and whether that destination is on screen.
module sprite_blit_addr
  import sprite_blit_pkg::*;
#(
  parameter int SPR_W = SPR_W_DEF,
  parameter int SPR_H = SPR_H_DEF,
  parameter int FB_W  = FB_W_DEF,
  parameter int FB_H  = FB_H_DEF,
  localparam int SXW  = $clog2(SPR_W),
  localparam int SYW  = $clog2(SPR_H)
) (
  input  logic [POS_W-1:0]      pos_x,
  input  logic [POS_W-1:0]      pos_y,
  input  logic [SXW-1:0]        sx,
  input  logic [SYW-1:0]        sy,
  input  logic                  flip,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  output logic [FB_ADDR_W-1:0]  fb_addr,
  output logic                  in_bounds
);
  logic [SXW-1:0] src_x;
  logic [POS_W:0] x, y;

  // One extra bit on x/y so positions near 1023 cannot wrap back on screen.
  always_comb begin
    src_x     = flip ? SXW'(SPR_W - 1) - sx : sx;
    x         = {1'b0, pos_x} + (POS_W+1)'(sx);
    y         = {1'b0, pos_y} + (POS_W+1)'(sy);
    in_bounds = (x < (POS_W+1)'(FB_W)) && (y < (POS_W+1)'(FB_H));
    rom_addr  = ROM_ADDR_W'(sy) * ROM_ADDR_W'(SPR_W) + ROM_ADDR_W'(src_x);
    fb_addr   = FB_ADDR_W'(y) * FB_ADDR_W'(FB_W) + FB_ADDR_W'(x);
  end
endmodule

// File: rtl/sprite_blitter.sv
// Copies one sprite from a sync ROM into the frame buffer, skipping transparent
// pixels and clipping at the screen edges. SPRITE_BLIT_FLIP_EN adds horizontal mirroring.
module sprite_blitter
  import sprite_blit_pkg::*;
#(
  parameter int SPR_W       = SPR_W_DEF,
  parameter int SPR_H       = SPR_H_DEF,
  parameter int FB_W        = FB_W_DEF,
  parameter int FB_H        = FB_H_DEF,
  parameter int IDX_W       = IDX_W_DEF,
  parameter int TRANSPARENT = 0
) (
  input  logic                  vga_clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [POS_W-1:0]      pos_x,
  input  logic [POS_W-1:0]      pos_y,
`ifdef SPRITE_BLIT_FLIP_EN
  input  logic                  flip,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]      rom_q,
  output logic                  fb_we,
  output logic [FB_ADDR_W-1:0]  fb_addr,
  output logic [IDX_W-1:0]      fb_data,
  input  logic                  fb_ready
);
  localparam int SXW = $clog2(SPR_W);
  localparam int SYW = $clog2(SPR_H);

  state_t             state, state_d;
  logic [SXW-1:0]     sx;
  logic [SYW-1:0]     sy;
  logic [POS_W-1:0]   px, py;
  logic               flip_q;
  logic               hold;
  logic [IDX_W-1:0]   pix_q, pix;
  logic [FB_ADDR_W-1:0] dst_addr;
  logic               in_bounds, wr_need, advance, last;

  sprite_blit_addr #(.SPR_W(SPR_W), .SPR_H(SPR_H), .FB_W(FB_W), .FB_H(FB_H)) u_addr (
    .pos_x(px), .pos_y(py), .sx(sx), .sy(sy), .flip(flip_q),
    .rom_addr(rom_addr), .fb_addr(dst_addr), .in_bounds(in_bounds)
  );

  // While stalled on fb_ready the ROM word is replayed from pix_q, so the
  // write stays stable even if the ROM output were to change.
  assign pix     = hold ? pix_q : rom_q;
  assign wr_need = (state == WRITE) && (pix != IDX_W'(TRANSPARENT)) && in_bounds;
  assign last    = (sx == SXW'(SPR_W - 1)) && (sy == SYW'(SPR_H - 1));
  assign fb_we   = wr_need;
  assign fb_addr = wr_need ? dst_addr : '0;
  assign fb_data = wr_need ? pix : '0;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_comb begin
    state_d = state;
    advance = 1'b0;
    case (state)
      IDLE:  if (start) state_d = FETCH;
      FETCH: state_d = WRITE;
      WRITE: if (!wr_need || fb_ready) begin
               advance = 1'b1;
               state_d = last ? DONE : FETCH;
             end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state  <= IDLE;
      sx     <= '0;
      sy     <= '0;
      px     <= '0;
      py     <= '0;
      flip_q <= 1'b0;
      hold   <= 1'b0;
      pix_q  <= '0;
    end else begin
      state <= state_d;
      hold  <= (state == WRITE) && !advance;
      pix_q <= pix;
      if (state == IDLE && start) begin
        px <= pos_x;
        py <= pos_y;
        sx <= '0;
        sy <= '0;
`ifdef SPRITE_BLIT_FLIP_EN
        flip_q <= flip;
`else
        flip_q <= 1'b0;
`endif
      end else if (advance && !last) begin
        if (sx == SXW'(SPR_W - 1)) begin
          sx <= '0;
          sy <= sy + 1'b1;
        end else begin
          sx <= sx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: random and directed sprites checked
// against a pixel-list model of the blit.
module tb_sprite_blitter;
  localparam int SW = 64, SH = 64, FW = 320, FH = 240;

  logic        vga_clk = 1'b0;
  logic        Reset = 1'b1, start = 1'b0, fb_ready = 1'b1;
  logic [9:0]  pos_x = '0, pos_y = '0;
  logic        busy, done, fb_we;
  logic [11:0] rom_addr;
  logic [3:0]  rom_q, fb_data;
  logic [16:0] fb_addr;
`ifdef SPRITE_BLIT_FLIP_EN
  logic        flip = 1'b0;
`endif

  logic [3:0] rom_mem [SW*SH];
  int errors = 0, checks = 0;
  int exp_a[$], got_a[$];
  logic [3:0] exp_d[$], got_d[$];
  int done_cyc, ndone, max_addr, stall_bad, stall_seen;
  logic busy_k1, busy_dn, busy_after;

  sprite_blitter dut (
    .vga_clk(vga_clk), .Reset(Reset), .start(start), .pos_x(pos_x), .pos_y(pos_y),
`ifdef SPRITE_BLIT_FLIP_EN
    .flip(flip),
`endif
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_q(rom_q),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready)
  );

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];

  // Reference: walk every sprite pixel, keep the opaque on-screen ones in raster order.
  task automatic build_expect(input int px, input int py, input bit fl);
    exp_a.delete(); exp_d.delete();
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++) begin
        int src, x, y;
        logic [3:0] v;
        src = fl ? SW - 1 - c : c;
        x = px + c; y = py + r;
        v = rom_mem[r*SW + src];
        if (v != 4'd0 && x < FW && y < FH) begin
          exp_a.push_back(y*FW + x);
          exp_d.push_back(v);
        end
      end
  endtask

  function automatic int first_diff();
    int n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
    for (int i = 0; i < n; i++)
      if (got_a[i] != exp_a[i] || got_d[i] !== exp_d[i]) return i;
    return (got_a.size() == exp_a.size()) ? -1 : n;
  endfunction

  // mode 0: always ready; 1: random fb_ready; 2: stall first write 5 cycles + stray start
  task automatic run_blit(input int px, input int py, input bit fl, input int mode);
    int stall = 0;
    logic [16:0] a0 = '0;
    logic [3:0]  d0 = '0;
    got_a.delete(); got_d.delete();
    done_cyc = -1; ndone = 0; max_addr = 0; stall_bad = 0; stall_seen = 0;
    busy_k1 = 1'b0; busy_dn = 1'b0; busy_after = 1'b1;
    @(negedge vga_clk);
    pos_x = 10'(px); pos_y = 10'(py); start = 1'b1; fb_ready = 1'b1;
`ifdef SPRITE_BLIT_FLIP_EN
    flip = fl;
`endif
    for (int k = 1; k <= 30000; k++) begin
      @(negedge vga_clk);
      start = (mode == 2 && k == 101);
      if (mode == 2 && k == 101) begin pos_x = 10'd50; pos_y = 10'd50; end
      #1;
      case (mode)
        1: fb_ready = ($urandom_range(0, 3) != 0);
        2: if (fb_we && stall < 5) begin
             if (stall == 0) begin a0 = fb_addr; d0 = fb_data; end
             else if (fb_addr !== a0 || fb_data !== d0) stall_bad++;
             stall++; stall_seen++; fb_ready = 1'b0;
           end else fb_ready = 1'b1;
        default: fb_ready = 1'b1;
      endcase
      if (fb_we && fb_ready) begin
        got_a.push_back(int'(fb_addr)); got_d.push_back(fb_data);
        if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
      end
      if (k == 1) busy_k1 = busy;
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin done_cyc = k; busy_dn = busy; end
      end
      if (done_cyc >= 0 && k == done_cyc + 1) busy_after = busy;
      if (done_cyc >= 0 && k >= done_cyc + 2) break;
    end
    start = 1'b0; fb_ready = 1'b1;
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < SW*SH; i++)
      case (kind)
        0: rom_mem[i] = 4'd5;
        1: rom_mem[i] = (i % 2 == 0) ? 4'd0 : 4'd9;
        2: rom_mem[i] = 4'd3;
        3: rom_mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        default: rom_mem[i] = (i % SW == 0) ? 4'd7 : 4'd0;
      endcase
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge vga_clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we: got %b want 0", fb_we); end
    checks++; if (fb_addr !== 17'd0) begin errors++; $display("FAIL reset_fb_addr: got %0d want 0", fb_addr); end
    checks++; if (fb_data !== 4'd0) begin errors++; $display("FAIL reset_fb_data: got %0d want 0", fb_data); end
    checks++; if (rom_addr !== 12'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    Reset = 1'b0;
  endtask

  task automatic test_full_opaque();
    int d;
    fill(0); build_expect(0, 0, 1'b0); run_blit(0, 0, 1'b0, 0);
    d = first_diff();
    checks++; if (got_a.size() != 4096) begin errors++; $display("FAIL full_count: got %0d want 4096", got_a.size()); end
    checks++; if ((got_a.size() > 0 ? got_a[0] : -1) != 0) begin errors++; $display("FAIL full_first_addr: got %0d want 0", got_a.size() > 0 ? got_a[0] : -1); end
    checks++; if ((got_a.size() > 0 ? got_a[$] : -1) != 20223) begin errors++; $display("FAIL full_last_addr: got %0d want 20223", got_a.size() > 0 ? got_a[$] : -1); end
    checks++; if (d != -1) begin errors++; $display("FAIL full_writes: first difference at index %0d", d); end
    checks++; if (done_cyc != 8193) begin errors++; $display("FAIL full_done_cycle: got %0d want 8193", done_cyc); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL full_done_pulses: got %0d want 1", ndone); end
    checks++; if (busy_k1 !== 1'b1 || busy_dn !== 1'b1 || busy_after !== 1'b0) begin
      errors++; $display("FAIL full_busy: got start+1=%b done=%b after=%b want 1 1 0", busy_k1, busy_dn, busy_after); end
  endtask

  task automatic test_transparency();
    int d, bad = 0;
    fill(1); build_expect(0, 0, 1'b0); run_blit(0, 0, 1'b0, 0);
    d = first_diff();
    foreach (got_a[i]) if (got_d[i] !== 4'd9 || got_a[i] % 2 == 0) bad++;
    checks++; if (got_a.size() != 2048) begin errors++; $display("FAIL transp_count: got %0d want 2048", got_a.size()); end
    checks++; if (bad != 0) begin errors++; $display("FAIL transp_data_odd: got %0d bad writes want 0", bad); end
    checks++; if (d != -1) begin errors++; $display("FAIL transp_writes: first difference at index %0d", d); end
    checks++; if (done_cyc != 8193) begin errors++; $display("FAIL transp_done_cycle: got %0d want 8193", done_cyc); end
  endtask

  task automatic test_clip();
    int d;
    fill(2); build_expect(300, 230, 1'b0); run_blit(300, 230, 1'b0, 0);
    d = first_diff();
    checks++; if (got_a.size() != 200) begin errors++; $display("FAIL clip_count: got %0d want 200", got_a.size()); end
    checks++; if ((got_a.size() > 0 ? got_a[$] : -1) != 76799) begin errors++; $display("FAIL clip_last_addr: got %0d want 76799", got_a.size() > 0 ? got_a[$] : -1); end
    checks++; if (max_addr >= 76800) begin errors++; $display("FAIL clip_max_addr: got %0d want below 76800", max_addr); end
    checks++; if (d != -1) begin errors++; $display("FAIL clip_writes: first difference at index %0d", d); end
    checks++; if (done_cyc != 8193) begin errors++; $display("FAIL clip_done_cycle: got %0d want 8193", done_cyc); end
  endtask

  task automatic test_backpressure();
    int d, extra = 0;
    fill(0); build_expect(0, 0, 1'b0); run_blit(0, 0, 1'b0, 2);
    d = first_diff();
    checks++; if (stall_seen != 5 || stall_bad != 0) begin
      errors++; $display("FAIL bp_stable: got %0d stalled cycles, %0d unstable want 5, 0", stall_seen, stall_bad); end
    checks++; if (got_a.size() != 4096) begin errors++; $display("FAIL bp_count: got %0d want 4096", got_a.size()); end
    checks++; if (d != -1) begin errors++; $display("FAIL bp_writes: first difference at index %0d", d); end
    checks++; if (done_cyc != 8198) begin errors++; $display("FAIL bp_done_cycle: got %0d want 8198", done_cyc); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL bp_done_pulses: got %0d want 1", ndone); end
    for (int k = 0; k < 20; k++) begin
      @(negedge vga_clk); #1;
      if (fb_we || done || busy) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL bp_no_second_blit: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_abort();
    int extra = 0;
    fill(0);
    @(negedge vga_clk); pos_x = 10'd0; pos_y = 10'd0; start = 1'b1;
    @(negedge vga_clk); start = 1'b0;
    @(negedge vga_clk); #1;
    checks++; if (fb_we !== 1'b1) begin errors++; $display("FAIL abort_in_write: got fb_we=%b want 1", fb_we); end
    Reset = 1'b1;
    @(negedge vga_clk); #1;
    checks++; if (fb_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rom_addr !== 12'd0) begin
      errors++; $display("FAIL abort_outputs: got we=%b busy=%b done=%b rom_addr=%0d want 0 0 0 0", fb_we, busy, done, rom_addr); end
    Reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge vga_clk); #1;
      if (fb_we || done) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 2; it++) begin
      int px, py, d;
      bit fl;
      px = $urandom_range(0, 339); py = $urandom_range(0, 259); fl = 1'b0;
`ifdef SPRITE_BLIT_FLIP_EN
      fl = 1'($urandom_range(0, 1));
`endif
      fill(3); build_expect(px, py, fl); run_blit(px, py, fl, 1);
      d = first_diff();
      checks++; if (d != -1) begin errors++; $display("FAIL rand_writes: pos (%0d,%0d) got %0d writes want %0d, first difference %0d", px, py, got_a.size(), exp_a.size(), d); end
      checks++; if (ndone != 1 || done_cyc < 8193) begin errors++; $display("FAIL rand_done: got %0d pulses at cycle %0d want 1 at or after 8193", ndone, done_cyc); end
    end
  endtask

`ifdef SPRITE_BLIT_FLIP_EN
  task automatic test_flip();
    int d, bad = 0;
    fill(4); build_expect(10, 0, 1'b1); run_blit(10, 0, 1'b1, 0);
    d = first_diff();
    foreach (got_a[i]) if (got_a[i] % FW != 73 || got_d[i] !== 4'd7) bad++;
    checks++; if (got_a.size() != 64) begin errors++; $display("FAIL flip_count: got %0d want 64", got_a.size()); end
    checks++; if (bad != 0) begin errors++; $display("FAIL flip_column: got %0d bad writes want 0", bad); end
    checks++; if (d != -1) begin errors++; $display("FAIL flip_writes: first difference at index %0d", d); end
  endtask
`endif

  initial begin
    fill(0);
    test_reset();
    test_full_opaque();
    test_transparency();
    test_clip();
    test_backpressure();
    test_reset_abort();
    test_random();
`ifdef SPRITE_BLIT_FLIP_EN
    test_flip();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
